// File: rtl/instr_prefetch_stage_if.sv
// -----------------------------------------------------------------------------
// instr_prefetch_stage_if
//   Bus bundle between the prefetcher, its instruction/register memories and
//   the decode stage.
//   Memory side : instr_read_addr (out of prefetcher), instr_read_val and
//                 regs_read_val (valid one cycle after the address).
//   Decode side : out_valid / out_ready handshake with the FIFO-head fields
//                 block_out, instr_out, regs_out, frame_last_out.
//   master = prefetcher view, slave = memory + consumer view.
// -----------------------------------------------------------------------------
interface instr_prefetch_stage_if #(
    parameter int data_width   = 16,
    parameter int n_blocks     = 256,
    parameter int n_block_regs = 2,
    parameter int instr_width  = 32
);
    localparam int AW = $clog2(n_blocks);
    localparam int RW = n_block_regs * data_width;

    logic [AW-1:0]          instr_read_addr;
    logic [instr_width-1:0] instr_read_val;
    logic [RW-1:0]          regs_read_val;
    logic                   out_valid;
    logic                   out_ready;
    logic [AW-1:0]          block_out;
    logic [instr_width-1:0] instr_out;
    logic [RW-1:0]          regs_out;
    logic                   frame_last_out;

    modport master (
        output instr_read_addr,
        input  instr_read_val, regs_read_val,
        output out_valid, block_out, instr_out, regs_out, frame_last_out,
        input  out_ready
    );

    modport slave (
        input  instr_read_addr,
        output instr_read_val, regs_read_val,
        input  out_valid, block_out, instr_out, regs_out, frame_last_out,
        output out_ready
    );
endinterface

// File: rtl/instr_prefetch_stage.sv
// -----------------------------------------------------------------------------
// instr_prefetch_stage
//   Frame-synchronised prefetcher: on each frame-start tick it walks blocks
//   0..last_block, reads each block's instruction and register words from
//   synchronous memories, and queues them (optionally dropping NOP blocks)
//   in a small FIFO presented to the decode stage over valid/ready.
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   enable            0 freezes issue and FSM transitions
//   sample_tick       one-cycle frame-start pulse
//   flush             drops the in-flight read and the FIFO contents
//   n_blocks_running  0 = pipeline idle (forces IDLE and flushes)
//   last_block        final block index, sampled once at frame start
//   fifo_level        FIFO occupancy
//   frame_overrun     one-cycle pulse when a tick arrives mid-frame
//   bus               memory read port and decode-side handshake
// -----------------------------------------------------------------------------
`ifndef BLOCK_INSTR_NOP
`define BLOCK_INSTR_NOP 5'd0
`endif

module instr_prefetch_stage #(
    parameter int data_width   = 16,
    parameter int n_blocks     = 256,
    parameter int n_block_regs = 2,
    parameter int instr_width  = 32,
    parameter int fifo_depth   = 4,
    parameter bit skip_nops    = 1'b1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              enable,
    input  logic                              sample_tick,
    input  logic                              flush,
    input  logic [$clog2(n_blocks)-1:0]       n_blocks_running,
    input  logic [$clog2(n_blocks)-1:0]       last_block,
    output logic [$clog2(fifo_depth+1)-1:0]   fifo_level,
    output logic                              frame_overrun,
    instr_prefetch_stage_if.master            bus
);
    localparam int AW = $clog2(n_blocks);
    localparam int RW = n_block_regs * data_width;
    localparam int PW = $clog2(fifo_depth);
    localparam int CW = $clog2(fifo_depth + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FETCH} state_t;

    typedef struct packed {
        logic [AW-1:0]          block;
        logic [instr_width-1:0] instr;
        logic [RW-1:0]          regs;
        logic                   last;
    } entry_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [AW-1:0]   frame_last_q, frame_last_d;
    logic            tick_pending_q, tick_pending_d;
    logic            inflight_q, inflight_d;
    logic [AW-1:0]   infl_block_q, infl_block_d;
    logic            infl_last_q, infl_last_d;
    logic            overrun_q, overrun_d;

    entry_t          fifo_q [fifo_depth];
    logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]   count_q;

    logic stop, flush_all, has_room, is_nop, push, pop;

    // Dropping n_blocks_running to 0 behaves like a flush plus a return to IDLE.
    assign stop      = (n_blocks_running == '0);
    assign flush_all = flush || stop;

    // No credit is taken for a same-cycle pop: the in-flight read always has a
    // guaranteed slot, so a push into a full FIFO can never happen.
    assign has_room  = (32'(count_q) + 32'(inflight_q)) < 32'(fifo_depth);

    // The last block is always pushed so frame_last_out reaches downstream.
    assign is_nop = (bus.instr_read_val[4:0] == `BLOCK_INSTR_NOP);
    assign push   = inflight_q && !flush_all && !(skip_nops && is_nop && !infl_last_q);
    assign pop    = (count_q != '0) && bus.out_ready && !flush_all;

    always_comb begin
        // NOTE: every variable driven here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d        = state_q;
        addr_d         = addr_q;
        frame_last_d   = frame_last_q;
        tick_pending_d = tick_pending_q;
        overrun_d      = 1'b0;
        inflight_d     = 1'b0;
        infl_block_d   = infl_block_q;
        infl_last_d    = infl_last_q;

        if (stop) begin
            state_d        = S_IDLE;
            addr_d         = '0;
            tick_pending_d = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (enable) state_d = S_WAIT;
                end
                S_WAIT: begin
                    // flush beats a simultaneous tick; a tick seen while
                    // disabled is remembered rather than lost.
                    if (!flush && (sample_tick || tick_pending_q)) begin
                        if (enable) begin
                            state_d        = S_FETCH;
                            addr_d         = '0;
                            frame_last_d   = last_block;
                            tick_pending_d = 1'b0;
                        end else begin
                            tick_pending_d = 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    if (flush) begin
                        state_d = S_WAIT;
                    end else begin
                        if (sample_tick) begin
                            overrun_d      = 1'b1;
                            tick_pending_d = 1'b1;
                        end
                        if (enable && has_room) begin
                            inflight_d   = 1'b1;
                            infl_block_d = addr_q;
                            infl_last_d  = (addr_q == frame_last_q);
                            if (addr_q == frame_last_q) state_d = S_WAIT;
                            else                        addr_d  = addr_q + AW'(1);
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            addr_q         <= '0;
            frame_last_q   <= '0;
            tick_pending_q <= 1'b0;
            inflight_q     <= 1'b0;
            infl_block_q   <= '0;
            infl_last_q    <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            frame_last_q   <= frame_last_d;
            tick_pending_q <= tick_pending_d;
            inflight_q     <= inflight_d;
            infl_block_q   <= infl_block_d;
            infl_last_q    <= infl_last_d;
            overrun_q      <= overrun_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the storage is reset too, because the head fields are read
            // straight from it and must be 0 out of reset.
            for (int i = 0; i < fifo_depth; i++) fifo_q[i] <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_all) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= '{block: infl_block_q,
                                      instr: bus.instr_read_val,
                                      regs:  bus.regs_read_val,
                                      last:  infl_last_q};
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign bus.instr_read_addr = addr_q;
    assign bus.out_valid       = (count_q != '0);
    assign bus.block_out       = fifo_q[rd_ptr_q].block;
    assign bus.instr_out       = fifo_q[rd_ptr_q].instr;
    assign bus.regs_out        = fifo_q[rd_ptr_q].regs;
    assign bus.frame_last_out  = fifo_q[rd_ptr_q].last;
    assign fifo_level          = count_q;
    assign frame_overrun       = overrun_q;
endmodule

// File: tb/tb_instr_prefetch_stage.sv
// -----------------------------------------------------------------------------
// tb_instr_prefetch_stage
//   Directed bench for instr_prefetch_stage. Expected blocks are pushed to a
//   scoreboard queue when a frame is started and popped/compared whenever the
//   DUT completes an out_valid/out_ready handshake.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
`ifndef BLOCK_INSTR_NOP
`define BLOCK_INSTR_NOP 5'd0
`endif

module tb_instr_prefetch_stage;
    localparam int DW = 16;
    localparam int NB = 256;
    localparam int NR = 2;
    localparam int IW = 32;
    localparam int FD = 4;
    localparam int AW = $clog2(NB);
    localparam int RW = NR * DW;
    localparam int CW = $clog2(FD + 1);

    typedef struct packed {
        logic [AW-1:0] block;
        logic [IW-1:0] instr;
        logic [RW-1:0] regs;
        logic          last;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          sample_tick;
    logic          flush;
    logic [AW-1:0] n_blocks_running;
    logic [AW-1:0] last_block;
    logic [CW-1:0] fifo_level;
    logic          frame_overrun;

    instr_prefetch_stage_if #(.data_width(DW), .n_blocks(NB),
                              .n_block_regs(NR), .instr_width(IW)) bus ();

    instr_prefetch_stage #(
        .data_width(DW), .n_blocks(NB), .n_block_regs(NR),
        .instr_width(IW), .fifo_depth(FD), .skip_nops(1'b1)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
        .sample_tick      (sample_tick),
        .flush            (flush),
        .n_blocks_running (n_blocks_running),
        .last_block       (last_block),
        .fifo_level       (fifo_level),
        .frame_overrun    (frame_overrun),
        .bus              (bus)
    );

    always #5 clk = ~clk;

    // Synchronous memories: data appears one cycle after the address.
    logic [IW-1:0] instr_mem [NB];
    logic [RW-1:0] regs_mem  [NB];

    always @(posedge clk) begin
        bus.instr_read_val <= instr_mem[bus.instr_read_addr];
        bus.regs_read_val  <= regs_mem[bus.instr_read_addr];
    end

    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t sb_q [$];
    exp_t mon_e;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick();
        sample_tick = 1'b1;
        step(1);
        sample_tick = 1'b0;
    endtask

    function automatic logic [IW-1:0] make_instr(input int b, input bit nop);
        return {8'(b), 8'hA5, 11'(b * 7), nop ? `BLOCK_INSTR_NOP : 5'd1};
    endfunction

    function automatic logic [RW-1:0] make_regs(input int b);
        return {16'(b * 3 + 1), 16'(32'hF00F ^ b)};
    endfunction

    // Reference model of one frame: NOPs dropped except on the last block.
    task automatic expect_frame(input int last);
        exp_t e;
        for (int b = 0; b <= last; b++) begin
            if (instr_mem[b][4:0] != `BLOCK_INSTR_NOP || b == last) begin
                e.block = AW'(b);
                e.instr = instr_mem[b];
                e.regs  = regs_mem[b];
                e.last  = (b == last);
                sb_q.push_back(e);
            end
        end
    endtask

    task automatic drain(input string tag, input int budget);
        int t = 0;
        while (sb_q.size() != 0 && t < budget) begin
            step(1);
            t++;
        end
        check({tag, "_left"}, 128'(sb_q.size()), 128'(0));
    endtask

    task automatic wait_addr(input string tag, input int a, input int budget);
        int t = 0;
        while (int'(bus.instr_read_addr) != a && t < budget) begin
            step(1);
            t++;
        end
        check(tag, 128'(bus.instr_read_addr), 128'(a));
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_valid"}, 128'(bus.out_valid), 128'(0));
        check({tag, "_level"}, 128'(fifo_level), 128'(0));
        check({tag, "_addr"},  128'(bus.instr_read_addr), 128'(0));
        check({tag, "_ovr"},   128'(frame_overrun), 128'(0));
        check({tag, "_head"},  128'({bus.block_out, bus.instr_out, bus.regs_out, bus.frame_last_out}), 128'(0));
    endtask

    // Scoreboard consumer: a handshake completes at the next rising edge.
    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready && !flush && n_blocks_running != '0) begin
            n_cmp++;
            assert (sb_q.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_out: observed block %0d expected no output", bus.block_out);
            end
            if (sb_q.size() != 0) begin
                mon_e = sb_q.pop_front();
                check("head", 128'({bus.block_out, bus.instr_out, bus.regs_out, bus.frame_last_out}),
                      128'(mon_e));
            end
        end
    end

    initial begin
        for (int b = 0; b < NB; b++) begin
            instr_mem[b] = make_instr(b, 1'b0);
            regs_mem[b]  = make_regs(b);
        end
        reset            = 1'b1;
        enable           = 1'b1;
        sample_tick      = 1'b0;
        flush            = 1'b0;
        n_blocks_running = '0;
        last_block       = AW'(3);
        bus.out_ready    = 1'b1;
        step(2);
        check_outputs_zero("reset");
        reset = 1'b0;
        step(1);

        // A tick while idle is ignored.
        tick();
        step(3);
        check("idle_tick_valid", 128'(bus.out_valid), 128'(0));
        check("idle_tick_addr",  128'(bus.instr_read_addr), 128'(0));

        // 1. Four blocks streamed back-to-back, first valid 2 cycles after tick.
        n_blocks_running = AW'(8);
        step(1);
        expect_frame(3);
        tick();
        check("t1_lat1", 128'(bus.out_valid), 128'(0));
        step(1);
        check("t1_lat2", 128'(bus.out_valid), 128'(0));
        step(1);
        check("t1_first_valid", 128'(bus.out_valid), 128'(1));
        check("t1_first_block", 128'(bus.block_out), 128'(0));
        for (int i = 1; i <= 3; i++) begin
            step(1);
            check("t1_stream_valid", 128'(bus.out_valid), 128'(1));
            check("t1_stream_block", 128'(bus.block_out), 128'(i));
            check("t1_stream_last",  128'(bus.frame_last_out), 128'(i == 3));
        end
        step(1);
        check("t1_end_valid", 128'(bus.out_valid), 128'(0));
        drain("t1", 10);

        // 2. NOP on block 1 is dropped, NOP on last block 3 is still emitted.
        instr_mem[1] = make_instr(1, 1'b1);
        instr_mem[3] = make_instr(3, 1'b1);
        expect_frame(3);
        tick();
        drain("t2", 30);
        step(2);
        check("t2_idle_valid", 128'(bus.out_valid), 128'(0));
        instr_mem[1] = make_instr(1, 1'b0);
        instr_mem[3] = make_instr(3, 1'b0);

        // 3. Back-pressure: issue stops at a full FIFO, nothing lost on release.
        bus.out_ready = 1'b0;
        last_block    = AW'(7);
        expect_frame(7);
        tick();
        step(12);
        check("t3_full_level", 128'(fifo_level), 128'(FD));
        check("t3_stall_addr", 128'(bus.instr_read_addr), 128'(4));
        check("t3_head_block", 128'(bus.block_out), 128'(0));
        step(5);
        check("t3_still_full", 128'(fifo_level), 128'(FD));
        bus.out_ready = 1'b1;
        drain("t3", 40);

        // 4. Tick during block 5 of 8: one overrun pulse, restart after block 7.
        expect_frame(7);
        expect_frame(7);
        tick();
        wait_addr("t4_reach5", 5, 20);
        sample_tick = 1'b1;
        step(1);
        sample_tick = 1'b0;
        check("t4_ovr_pulse", 128'(frame_overrun), 128'(1));
        step(1);
        check("t4_ovr_clear", 128'(frame_overrun), 128'(0));
        wait_addr("t4_reach7", 7, 20);
        step(1);
        check("t4_wait_addr", 128'(bus.instr_read_addr), 128'(7));
        step(1);
        check("t4_restart_addr", 128'(bus.instr_read_addr), 128'(0));
        drain("t4", 40);

        // 5. Flush with 3 entries queued and one read in flight.
        bus.out_ready = 1'b0;
        tick();
        begin
            int t = 0;
            while (fifo_level != CW'(3) && t < 20) begin
                step(1);
                t++;
            end
        end
        check("t5_level3", 128'(fifo_level), 128'(3));
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        check("t5_flush_valid", 128'(bus.out_valid), 128'(0));
        check("t5_flush_level", 128'(fifo_level), 128'(0));
        bus.out_ready = 1'b1;
        step(10);
        check("t5_no_stale", 128'(bus.out_valid), 128'(0));

        // 6. Reset mid-frame with the pipeline going idle.
        bus.out_ready = 1'b0;
        tick();
        step(4);
        reset            = 1'b1;
        n_blocks_running = '0;
        #1;
        check_outputs_zero("t6_reset");
        step(2);
        reset = 1'b0;
        step(1);
        tick();
        step(4);
        check_outputs_zero("t6_idle");
        n_blocks_running = AW'(8);
        bus.out_ready    = 1'b1;
        step(4);
        check("t6_no_tick_valid", 128'(bus.out_valid), 128'(0));
        check("t6_no_tick_addr",  128'(bus.instr_read_addr), 128'(0));
        last_block = AW'(2);
        expect_frame(2);
        tick();
        drain("t6", 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
